calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer_if.sv | 39 +++
 rtl/calc_sequencer.sv | 149 ++++++++++++++
 tb/tb_calc_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer_if
// Purpose  : Bundles the operator-panel inputs, the ALU handshake and the
//            status outputs of calc_sequencer into one port.
// Ports    : sw[7:0], op[1:0], enter, clear, alu_done  -> into the sequencer
//            a_reg[7:0], b_reg[7:0], op_reg[1:0], alu_start, ans_en,
//            state[2:0], busy, err                      <- from the sequencer
// Modports : master - the sequencer itself (it commands the ALU)
//            slave  - the surrounding panel/ALU environment
// Revision : 1.0 - initial release
// ============================================================================
interface calc_sequencer_if;
  logic [7:0] sw;
  logic [1:0] op;
  logic       enter;
  logic       clear;
  logic       alu_done;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [1:0] op_reg;
  logic       alu_start;
  logic       ans_en;
  logic [2:0] state;
  logic       busy;
  logic       err;

  modport master (
    input  sw, op, enter, clear, alu_done,
    output a_reg, b_reg, op_reg, alu_start, ans_en, state, busy, err
  );

  modport slave (
    output sw, op, enter, clear, alu_done,
    input  a_reg, b_reg, op_reg, alu_start, ans_en, state, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Operand entry and ALU sequencing for a push-button calculator.
//            Captures operand A, then operand B plus operation, launches the
//            ALU, waits (bounded by TIMEOUT cycles) for its done pulse and
//            then shows the answer until the next press.
// Params   : TIMEOUT - cycles allowed in EXEC before flagging ERR (2..255)
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-low reset
//            bus   - calc_sequencer_if.master (panel inputs, ALU handshake,
//                    captured operands and status)
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    WAIT_B = 3'd1,
    EXEC   = 3'd2,
    SHOW   = 3'd3,
    ERR    = 3'd4
  } state_e;

  // Counter value seen during the last permitted EXEC cycle.
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q,     state_d;
  logic [7:0] a_q,         a_d;
  logic [7:0] b_q,         b_d;
  logic [1:0] op_q,        op_d;
  logic [7:0] cnt_q,       cnt_d;
  logic       alu_start_q, alu_start_d;
  logic       ans_en_q,    ans_en_d;
  logic       enter_q,     enter_d;
  logic       arm_q,       arm_d;
  logic       enter_rise;

  // arm_q stays low until enter has been seen low at least once after reset,
  // so a button held through reset release cannot fake a press even though
  // enter_q restarts at 0.
  assign enter_d    = bus.enter;
  assign arm_d      = arm_q | ~bus.enter;
  assign enter_rise = bus.enter & ~enter_q & arm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      alu_start_q <= 1'b0;
      ans_en_q    <= 1'b0;
      enter_q     <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      alu_start_q <= alu_start_d;
      ans_en_q    <= ans_en_d;
      enter_q     <= enter_d;
      arm_q       <= arm_d;
    end
  end

  // alu_start/ans_en are computed on the transition into EXEC/SHOW so the
  // registered pulse lines up with the first cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    alu_start_d = 1'b0;
    ans_en_d    = 1'b0;

    if (bus.clear) begin
      // Abort outranks any press or ALU completion in the same cycle.
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter_rise) begin
            a_d     = bus.sw;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_rise) begin
            b_d         = bus.sw;
            op_d        = bus.op;
            cnt_d       = '0;
            alu_start_d = 1'b1;
            state_d     = EXEC;
          end
        end
        EXEC: begin
          cnt_d = cnt_q + 8'd1;
          // Completion is checked first so it wins over a coincident timeout.
          if (bus.alu_done) begin
            ans_en_d = 1'b1;
            state_d  = SHOW;
          end else if (cnt_q == C_CNT_LAST) begin
            state_d = ERR;
          end
        end
        SHOW: begin
          if (enter_rise) begin
            state_d = WAIT_A;
          end
        end
        ERR: begin
          if (enter_rise) begin
            state_d = WAIT_A;
          end
        end
        default: begin
          // Unused encodings fall back to the idle entry state.
          state_d = WAIT_A;
        end
      endcase
    end
  end

  assign bus.a_reg     = a_q;
  assign bus.b_reg     = b_q;
  assign bus.op_reg    = op_q;
  assign bus.alu_start = alu_start_q;
  assign bus.ans_en    = ans_en_q;
  assign bus.state     = state_q;
  assign bus.busy      = (state_q == EXEC);
  assign bus.err       = (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Self-checking bench for calc_sequencer. Directed stimulus pushes
//            the expected alu_start / ans_en events into a scoreboard queue;
//            a monitor pops and compares whenever the DUT pulses one of them.
//            State/operand snapshots are compared directly by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

  typedef struct {
    bit         is_ans;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t mon_e;

  calc_sequencer_if ifc ();

  calc_sequencer #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] v, input logic [1:0] o);
    ifc.sw    = v;
    ifc.op    = o;
    ifc.enter = 1'b1;
    tick(1);
    ifc.enter = 1'b0;
    tick(1);
  endtask

  task automatic push_start(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    exp_t e;
    e.is_ans = 1'b0; e.a = a; e.b = b; e.op = o;
    sb.push_back(e);
  endtask

  task automatic push_ans(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    exp_t e;
    e.is_ans = 1'b1; e.a = a; e.b = b; e.op = o;
    sb.push_back(e);
  endtask

  // Monitor: every alu_start / ans_en pulse must match the next queued event.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ifc.alu_start === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_start: got unexpected alu_start at %0t, required none", $time);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_ans) begin
            checks++; errors++;
            $display("FAIL sb_order: got alu_start at %0t, required ans_en", $time);
          end else begin
            chk("sb_start_a", 32'(ifc.a_reg), 32'(mon_e.a));
            chk("sb_start_b", 32'(ifc.b_reg), 32'(mon_e.b));
            chk("sb_start_op", 32'(ifc.op_reg), 32'(mon_e.op));
            chk("sb_start_state", 32'(ifc.state), 32'd2);
          end
        end
      end
      if (ifc.ans_en === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_ans: got unexpected ans_en at %0t, required none", $time);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.is_ans) begin
            checks++; errors++;
            $display("FAIL sb_order: got ans_en at %0t, required alu_start", $time);
          end else begin
            chk("sb_ans_a", 32'(ifc.a_reg), 32'(mon_e.a));
            chk("sb_ans_b", 32'(ifc.b_reg), 32'(mon_e.b));
            chk("sb_ans_op", 32'(ifc.op_reg), 32'(mon_e.op));
            chk("sb_ans_state", 32'(ifc.state), 32'd3);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ifc.sw = 8'h00; ifc.op = 2'd0; ifc.enter = 1'b0;
    ifc.clear = 1'b0; ifc.alu_done = 1'b0;

    // Reset state, applied between clock edges.
    #2 reset = 1'b0;
    #1;
    chk("rst_state", 32'(ifc.state), 32'd0);
    chk("rst_a", 32'(ifc.a_reg), 32'd0);
    chk("rst_outs", {26'd0, ifc.alu_start, ifc.ans_en, ifc.busy, ifc.err, ifc.op_reg}, 32'd0);
    #9 reset = 1'b1;
    tick(1);

    // Normal operation: 0x12, then 0x34 op 2, done 3 cycles after start.
    press(8'h12, 2'd0);
    chk("norm_state_b", 32'(ifc.state), 32'd1);
    chk("norm_a", 32'(ifc.a_reg), 32'h12);
    push_start(8'h12, 8'h34, 2'd2);
    press(8'h34, 2'd2);
    chk("norm_busy", 32'(ifc.busy), 32'd1);
    tick(2);
    ifc.alu_done = 1'b1;
    push_ans(8'h12, 8'h34, 2'd2);
    tick(1);
    ifc.alu_done = 1'b0;
    chk("norm_state_show", 32'(ifc.state), 32'd3);
    chk("norm_ans_en_hi", 32'(ifc.ans_en), 32'd1);
    chk("norm_b", 32'(ifc.b_reg), 32'h34);
    chk("norm_op", 32'(ifc.op_reg), 32'd2);
    tick(1);
    chk("norm_ans_en_lo", 32'(ifc.ans_en), 32'd0);

    // Stray alu_done in SHOW, WAIT_A, WAIT_B.
    ifc.alu_done = 1'b1; tick(1); ifc.alu_done = 1'b0; tick(1);
    chk("stray_show_state", 32'(ifc.state), 32'd3);
    press(8'hEE, 2'd1);
    chk("show_exit_state", 32'(ifc.state), 32'd0);
    chk("show_keep_a", 32'(ifc.a_reg), 32'h12);
    ifc.alu_done = 1'b1; tick(1); ifc.alu_done = 1'b0; tick(1);
    chk("stray_wa_state", 32'(ifc.state), 32'd0);
    press(8'h05, 2'd1);
    ifc.alu_done = 1'b1; tick(1); ifc.alu_done = 1'b0; tick(1);
    chk("stray_wb_state", 32'(ifc.state), 32'd1);

    // Clear racing a press in WAIT_B.
    ifc.sw = 8'h77; ifc.op = 2'd3; ifc.clear = 1'b1; ifc.enter = 1'b1;
    tick(1);
    ifc.clear = 1'b0; ifc.enter = 1'b0;
    chk("clr_state", 32'(ifc.state), 32'd0);
    chk("clr_b", 32'(ifc.b_reg), 32'd0);
    chk("clr_a", 32'(ifc.a_reg), 32'd0);
    tick(2);
    chk("clr_no_start", 32'(ifc.state), 32'd0);

    // Timeout: ERR exactly 16 cycles after entering EXEC.
    press(8'h01, 2'd3);
    push_start(8'h01, 8'h02, 2'd1);
    press(8'h02, 2'd1);
    tick(14);
    chk("tmo_state_15", 32'(ifc.state), 32'd2);
    tick(1);
    chk("tmo_state_16", 32'(ifc.state), 32'd4);
    chk("tmo_err", 32'(ifc.err), 32'd1);
    press(8'h00, 2'd0);
    chk("tmo_exit_state", 32'(ifc.state), 32'd0);
    chk("tmo_exit_err", 32'(ifc.err), 32'd0);

    // Enter held 50 cycles yields a single capture.
    ifc.sw = 8'h3C; ifc.enter = 1'b1;
    tick(1);
    ifc.sw = 8'h99;
    tick(49);
    chk("hold_state", 32'(ifc.state), 32'd1);
    chk("hold_a", 32'(ifc.a_reg), 32'h3C);
    ifc.enter = 1'b0;
    tick(1);

    // alu_done on the timeout cycle wins.
    push_start(8'h3C, 8'h0F, 2'd0);
    press(8'h0F, 2'd0);
    tick(14);
    ifc.alu_done = 1'b1;
    push_ans(8'h3C, 8'h0F, 2'd0);
    tick(1);
    ifc.alu_done = 1'b0;
    chk("race_state", 32'(ifc.state), 32'd3);
    chk("race_err", 32'(ifc.err), 32'd0);
    press(8'h00, 2'd0);

    // Asynchronous reset in the middle of EXEC.
    press(8'h11, 2'd0);
    push_start(8'h11, 8'h22, 2'd1);
    press(8'h22, 2'd1);
    tick(2);
    #3 reset = 1'b0;
    #1;
    chk("arst_state", 32'(ifc.state), 32'd0);
    chk("arst_regs", {14'd0, ifc.a_reg, ifc.b_reg, ifc.op_reg}, 32'd0);
    chk("arst_flags", {28'd0, ifc.alu_start, ifc.ans_en, ifc.busy, ifc.err}, 32'd0);
    #2 reset = 1'b1;
    tick(1);
    ifc.alu_done = 1'b1;
    tick(1);
    ifc.alu_done = 1'b0;
    chk("arst_no_ans", 32'(ifc.ans_en), 32'd0);
    chk("arst_stay", 32'(ifc.state), 32'd0);

    // Enter held through reset release must not count as a press.
    #3 reset = 1'b0;
    ifc.sw = 8'h55; ifc.enter = 1'b1;
    #2 reset = 1'b1;
    tick(3);
    chk("hold_rst_state", 32'(ifc.state), 32'd0);
    chk("hold_rst_a", 32'(ifc.a_reg), 32'd0);
    ifc.enter = 1'b0;
    tick(1);
    ifc.sw = 8'h44; ifc.enter = 1'b1;
    tick(1);
    ifc.enter = 1'b0;
    chk("rearm_state", 32'(ifc.state), 32'd1);
    chk("rearm_a", 32'(ifc.a_reg), 32'h44);
    tick(2);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
